// File: rtl/can_rx_deframer.sv
// can_rx_deframer: receive-side CAN 2.0A (standard frame) deframer.
// Acts only on bit_strobe cycles. It removes stuff bits and checks the CRC-15,
// the fixed-form fields and the EOF. It drives the ACK slot and presents the
// last good frame on rx_*.
// Ports:
//   GCLK, RES              clock and synchronous active-high reset
//   rx_bit, bit_strobe     sampled bus level (1 = recessive) and sample-point pulse
//   ack_drive              request a dominant level on the bus during the ACK slot
//   rx_id/rx_rtr/rx_dlc/rx_data  fields of the last good frame (held between frames)
//   rx_ready               one-cycle pulse per good frame
//   err_stuff/err_crc/err_form   one-cycle error pulses
//   busy                   high from SOF until the frame ends or is aborted
module can_rx_deframer #(
  parameter int IDLE_BITS = 11
) (
  input  logic        GCLK,
  input  logic        RES,
  input  logic        rx_bit,
  input  logic        bit_strobe,
  output logic        ack_drive,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_ready,
  output logic        err_stuff,
  output logic        err_crc,
  output logic        err_form,
  output logic        busy
);
  localparam int IW = (IDLE_BITS < 2) ? 1 : $clog2(IDLE_BITS);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

  typedef enum logic [3:0] {
    IDLE_WAIT, WAIT_SOF, ID, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, ERROR
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idle_cnt_q;
  logic [6:0]    bit_cnt_q;
  logic [2:0]    run_len_q;
  logic          last_bit_q;
  logic [14:0]   crc_q, crc_rx_q;
  logic [10:0]   id_q;
  logic          rtr_q;
  logic [3:0]    dlc_q, nbytes_q;
  logic [63:0]   data_q;
  logic          ack_q, rx_ready_q, err_stuff_q, err_crc_q, err_form_q, busy_q;
  logic [10:0]   rx_id_q;
  logic          rx_rtr_q;
  logic [3:0]    rx_dlc_q;
  logic [63:0]   rx_data_q;

  logic [14:0] crc_d;
  logic [3:0]  dlc_d, nbytes_d;
  logic [6:0]  data_last;
  logic        destuff_en, stuff_slot;

  always_comb begin
    crc_d = {crc_q[13:0], 1'b0} ^ ((rx_bit ^ crc_q[14]) ? 15'h4599 : 15'h0000);
    dlc_d = {dlc_q[2:0], rx_bit};
    if (rtr_q)              nbytes_d = 4'd0;
    else if (dlc_d > 4'd8)  nbytes_d = 4'd8;
    else                    nbytes_d = dlc_d;
    data_last  = {nbytes_q, 3'b000} - 7'd1;
    destuff_en = (state_q == ID) || (state_q == CTRL) || (state_q == DATA) || (state_q == CRC);
    // A bit after five equal bits in the stuffed region is a stuff bit.
    stuff_slot = destuff_en && (run_len_q == 3'd5);
  end

  always_ff @(posedge GCLK) begin
    if (RES) begin
      state_q     <= IDLE_WAIT;
      idle_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      run_len_q   <= '0;
      last_bit_q  <= 1'b0;
      crc_q       <= '0;
      crc_rx_q    <= '0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      nbytes_q    <= '0;
      data_q      <= '0;
      ack_q       <= 1'b0;
      rx_ready_q  <= 1'b0;
      err_stuff_q <= 1'b0;
      err_crc_q   <= 1'b0;
      err_form_q  <= 1'b0;
      busy_q      <= 1'b0;
      rx_id_q     <= '0;
      rx_rtr_q    <= 1'b0;
      rx_dlc_q    <= '0;
      rx_data_q   <= '0;
    end else begin
      rx_ready_q  <= 1'b0;
      err_stuff_q <= 1'b0;
      err_crc_q   <= 1'b0;
      err_form_q  <= 1'b0;
      if (bit_strobe) begin
        if (stuff_slot) begin
          if (rx_bit == last_bit_q) begin
            err_stuff_q <= 1'b1;
            busy_q      <= 1'b0;
            idle_cnt_q  <= '0;
            state_q     <= ERROR;
          end else begin
            // Discarded stuff bit opens a new run of length 1.
            last_bit_q <= rx_bit;
            run_len_q  <= 3'd1;
          end
        end else begin
          if (destuff_en) begin
            if (rx_bit == last_bit_q) begin
              run_len_q <= run_len_q + 3'd1;
            end else begin
              run_len_q  <= 3'd1;
              last_bit_q <= rx_bit;
            end
          end
          case (state_q)
            IDLE_WAIT, ERROR: begin
              if (!rx_bit)                       idle_cnt_q <= '0;
              else if (idle_cnt_q == IDLE_LAST) begin
                idle_cnt_q <= '0;
                state_q    <= WAIT_SOF;
              end else                           idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            WAIT_SOF: begin
              if (!rx_bit) begin
                // SOF: a dominant bit fed into a zero CRC leaves it zero.
                state_q    <= ID;
                busy_q     <= 1'b1;
                crc_q      <= '0;
                crc_rx_q   <= '0;
                run_len_q  <= 3'd1;
                last_bit_q <= 1'b0;
                bit_cnt_q  <= '0;
                data_q     <= '0;
              end
            end
            ID: begin
              crc_q <= crc_d;
              id_q  <= {id_q[9:0], rx_bit};
              if (bit_cnt_q == 7'd10) begin
                bit_cnt_q <= '0;
                state_q   <= CTRL;
              end else bit_cnt_q <= bit_cnt_q + 7'd1;
            end
            CTRL: begin
              crc_q     <= crc_d;
              bit_cnt_q <= bit_cnt_q + 7'd1;
              if (bit_cnt_q == 7'd0) rtr_q <= rx_bit;
              if (bit_cnt_q >= 7'd3) dlc_q <= dlc_d;
              if (bit_cnt_q == 7'd1 && rx_bit) begin
                err_form_q <= 1'b1;
                busy_q     <= 1'b0;
                idle_cnt_q <= '0;
                state_q    <= ERROR;
              end else if (bit_cnt_q == 7'd6) begin
                bit_cnt_q <= '0;
                nbytes_q  <= nbytes_d;
                state_q   <= (nbytes_d == 4'd0) ? CRC : DATA;
              end
            end
            DATA: begin
              crc_q <= crc_d;
              // Bit k of the payload lands at [63-k] so byte 0 ends up in [63:56].
              data_q[6'(7'd63 - bit_cnt_q)] <= rx_bit;
              if (bit_cnt_q == data_last) begin
                bit_cnt_q <= '0;
                state_q   <= CRC;
              end else bit_cnt_q <= bit_cnt_q + 7'd1;
            end
            CRC: begin
              crc_rx_q <= {crc_rx_q[13:0], rx_bit};
              if (bit_cnt_q == 7'd14) begin
                bit_cnt_q <= '0;
                state_q   <= CRC_DEL;
              end else bit_cnt_q <= bit_cnt_q + 7'd1;
            end
            CRC_DEL: begin
              if (crc_rx_q != crc_q) begin
                err_crc_q  <= 1'b1;
                busy_q     <= 1'b0;
                idle_cnt_q <= '0;
                state_q    <= ERROR;
              end else if (!rx_bit) begin
                err_form_q <= 1'b1;
                busy_q     <= 1'b0;
                idle_cnt_q <= '0;
                state_q    <= ERROR;
              end else begin
                ack_q   <= 1'b1;
                state_q <= ACK_SLOT;
              end
            end
            ACK_SLOT: begin
              ack_q   <= 1'b0;
              state_q <= ACK_DEL;
            end
            ACK_DEL, EOF: begin
              if (!rx_bit) begin
                err_form_q <= 1'b1;
                busy_q     <= 1'b0;
                idle_cnt_q <= '0;
                state_q    <= ERROR;
              end else if (state_q == ACK_DEL) begin
                bit_cnt_q <= '0;
                state_q   <= EOF;
              end else if (bit_cnt_q == 7'd6) begin
                rx_id_q    <= id_q;
                rx_rtr_q   <= rtr_q;
                rx_dlc_q   <= dlc_q;
                rx_data_q  <= data_q;
                rx_ready_q <= 1'b1;
                busy_q     <= 1'b0;
                state_q    <= WAIT_SOF;
              end else bit_cnt_q <= bit_cnt_q + 7'd1;
            end
            default: state_q <= IDLE_WAIT;
          endcase
        end
      end
    end
  end

  assign ack_drive = ack_q;
  assign rx_id     = rx_id_q;
  assign rx_rtr    = rx_rtr_q;
  assign rx_dlc    = rx_dlc_q;
  assign rx_data   = rx_data_q;
  assign rx_ready  = rx_ready_q;
  assign err_stuff = err_stuff_q;
  assign err_crc   = err_crc_q;
  assign err_form  = err_form_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_can_rx_deframer.sv
// Randomized bench for can_rx_deframer. Frames are assembled as plain bit lists,
// CRC-protected and bit-stuffed. Some frames get a single injected error.
// The expected outcome of each frame is queued. A monitor pops one entry per
// rx_ready / error pulse and compares it.
module tb_can_rx_deframer;
  localparam int P    = 4;   // GCLK cycles per bit
  localparam int IDLE = 11;
  localparam logic [2:0] K_READY = 3'd0, K_STUFF = 3'd1, K_CRC = 3'd2, K_FORM = 3'd3;

  logic        GCLK = 1'b0;
  logic        RES, rx_bit, bit_strobe;
  logic        ack_drive, rx_rtr, rx_ready, err_stuff, err_crc, err_form, busy;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;

  can_rx_deframer #(.IDLE_BITS(IDLE)) dut (
    .GCLK(GCLK), .RES(RES), .rx_bit(rx_bit), .bit_strobe(bit_strobe),
    .ack_drive(ack_drive), .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
    .rx_data(rx_data), .rx_ready(rx_ready), .err_stuff(err_stuff),
    .err_crc(err_crc), .err_form(err_form), .busy(busy)
  );

  always #5 GCLK = ~GCLK;

  typedef struct packed {
    logic [2:0]  kind;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [7:0]  ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  bit u[$];        // unstuffed bits SOF..CRC
  bit s[$];        // transmitted bits, stuffed region plus tail
  int upos[$];     // position in s of each u bit
  int stuffpos[$]; // positions in s of stuff bits
  int tail0;       // position of CRC delimiter in s

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge GCLK);
    rx_bit     = b;
    bit_strobe = 1'b1;
    @(negedge GCLK);
    bit_strobe = 1'b0;
    rx_bit     = 1'($urandom_range(0, 1));   // don't-care between strobes
    repeat (P - 2) @(negedge GCLK);
  endtask

  function automatic logic [14:0] crc_of(input int n);
    logic [14:0] c = '0;
    for (int i = 0; i < n; i++) begin
      if ((u[i] ^ c[14]) == 1'b1) c = {c[13:0], 1'b0} ^ 15'h4599;
      else                        c = {c[13:0], 1'b0};
    end
    return c;
  endfunction

  task automatic build(input logic [10:0] id, input bit rtr, input bit ide, input logic [3:0] dlc,
                       input logic [63:0] data, input bit flip, input int flip_idx,
                       output logic [63:0] exp_data);
    int nb, run;
    bit last;
    logic [14:0] c;
    u.delete(); s.delete(); upos.delete(); stuffpos.delete();
    exp_data = '0;
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(id[i]);
    u.push_back(rtr);
    u.push_back(ide);
    u.push_back(1'($urandom_range(0, 1)));   // r0, ignored by the receiver
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < 8 * nb; i++) begin
      u.push_back(data[63 - i]);
      exp_data[63 - i] = data[63 - i];
    end
    c = crc_of(u.size());
    if (flip) c[flip_idx] = ~c[flip_idx];
    for (int i = 14; i >= 0; i--) u.push_back(c[i]);
    run  = 0;
    last = ~u[0];
    foreach (u[i]) begin
      if (run == 5) begin
        s.push_back(~last);
        stuffpos.push_back(s.size() - 1);
        last = ~last;
        run  = 1;
      end
      upos.push_back(s.size());
      s.push_back(u[i]);
      if (u[i] == last) run++;
      else begin run = 1; last = u[i]; end
    end
    tail0 = s.size();
    s.push_back(1'b1);                        // CRC delimiter
    s.push_back(1'($urandom_range(0, 1)));    // ACK slot, ignored
    s.push_back(1'b1);                        // ACK delimiter
    for (int i = 0; i < 7; i++) s.push_back(1'b1);
  endtask

  // inj: 0 none, 1 CRC bit flip, 2 stuff violation, 3 dominant CRC delimiter,
  //      4 dominant ACK delimiter, 5 dominant EOF bit number arg
  task automatic run_frame(input logic [10:0] id, input bit rtr, input bit ide, input logic [3:0] dlc,
                           input logic [63:0] data, input int inj, input int arg);
    exp_t e;
    logic [63:0] ed;
    int cut, p;
    build(id, rtr, ide, dlc, data, inj == 1, arg, ed);
    e.id = id; e.rtr = rtr; e.dlc = dlc; e.data = ed;
    e.kind = K_READY; e.ack = 8'(P); cut = s.size() - 1;
    if (ide) begin
      e.kind = K_FORM; e.ack = 0; cut = upos[13];
    end else begin
      case (inj)
        1: begin e.kind = K_CRC; e.ack = 0; cut = tail0; end
        2: if (stuffpos.size() > 0) begin
             p = stuffpos[arg % stuffpos.size()];
             s[p] = s[p - 1];
             e.kind = K_STUFF; e.ack = 0; cut = p;
           end
        3: begin s[tail0] = 1'b0; e.kind = K_FORM; e.ack = 0; cut = tail0; end
        4: begin s[tail0 + 2] = 1'b0; e.kind = K_FORM; cut = tail0 + 2; end
        5: begin s[tail0 + 3 + arg] = 1'b0; e.kind = K_FORM; cut = tail0 + 3 + arg; end
        default: ;
      endcase
    end
    exp_q.push_back(e);
    send_bit(s[0]);
    check("busy_after_sof", busy, 1);
    for (int i = 1; i <= cut; i++) send_bit(s[i]);
    if (e.kind != K_READY) repeat (IDLE) send_bit(1'b1);
    else repeat ($urandom_range(0, 2)) send_bit(1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, ack_drive, 0);
    check({tag, "_id"}, rx_id, 0);
    check({tag, "_rtr"}, rx_rtr, 0);
    check({tag, "_dlc"}, rx_dlc, 0);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_flags"}, {rx_ready, err_stuff, err_crc, err_form}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Monitor / scoreboard
  logic [10:0] last_id;
  logic        last_rtr;
  logic [3:0]  last_dlc;
  logic [63:0] last_data;
  int          ack_cnt, nev;
  logic [2:0]  kind_act;
  exp_t        m;

  always @(negedge GCLK) begin
    if (RES === 1'b1) begin
      last_id = '0; last_rtr = 1'b0; last_dlc = '0; last_data = '0; ack_cnt = 0;
    end else begin
      if (ack_drive === 1'b1) ack_cnt++;
      nev = int'(rx_ready) + int'(err_stuff) + int'(err_crc) + int'(err_form);
      if (nev != 0) begin
        if (nev > 1) check("single_flag", nev, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_event", {rx_ready, err_stuff, err_crc, err_form}, 0);
        end else begin
          m = exp_q.pop_front();
          kind_act = rx_ready ? K_READY : err_stuff ? K_STUFF : err_crc ? K_CRC : K_FORM;
          check("event_kind", kind_act, m.kind);
          check("ack_cycles", ack_cnt, m.ack);
          check("busy_at_end", busy, 0);
          if (m.kind == K_READY) begin
            last_id = m.id; last_rtr = m.rtr; last_dlc = m.dlc; last_data = m.data;
          end
          check("rx_id", rx_id, last_id);
          check("rx_rtr", rx_rtr, last_rtr);
          check("rx_dlc", rx_dlc, last_dlc);
          check("rx_data", rx_data, last_data);
          $display("event kind=%0d id=%0h dlc=%0d data=%016h ack=%0d", kind_act, rx_id, rx_dlc, rx_data, ack_cnt);
        end
        ack_cnt = 0;
      end
    end
  end

  initial begin
    logic [63:0] ed;
    logic [10:0] rid;
    logic [3:0]  rdlc;
    logic [63:0] rdata;
    bit          rrtr, ride;
    int          sel, inj, arg;

    RES = 1'b1; rx_bit = 1'b1; bit_strobe = 1'b0;
    repeat (3) @(negedge GCLK);
    check_zero("reset");
    RES = 1'b0;
    repeat (IDLE) send_bit(1'b1);

    run_frame(11'h123, 0, 0, 4'd2, 64'hA55A_0000_0000_0000, 0, 0);
    run_frame(11'h000, 0, 0, 4'd0, 64'h0, 2, 0);               // first stuff bit violated
    run_frame(11'h7FF, 0, 0, 4'd1, 64'hFF00_0000_0000_0000, 1, 0);
    run_frame(11'h2AB, 0, 0, 4'd12, 64'h0102_0304_0506_0708, 0, 0);
    run_frame(11'h555, 1, 0, 4'd4, 64'hDEAD_BEEF_0BAD_F00D, 0, 0);
    run_frame(11'h100, 0, 1, 4'd3, 64'h1122_3344_5566_7788, 0, 0);
    run_frame(11'h0F0, 0, 0, 4'd3, 64'h1234_5600_0000_0000, 5, 2);
    run_frame(11'h321, 0, 0, 4'd1, 64'h8000_0000_0000_0000, 3, 0);
    run_frame(11'h456, 0, 0, 4'd0, 64'h0, 4, 0);
    run_frame(11'h3C3, 0, 0, 4'd8, 64'hCAFE_F00D_1234_5678, 0, 0);

    // Reset in the middle of the payload of a frame.
    build(11'h3C3, 0, 0, 4'd8, 64'h0F1E_2D3C_4B5A_6978, 0, 0, ed);
    for (int i = 0; i <= upos[29]; i++) send_bit(s[i]);
    @(negedge GCLK);
    RES = 1'b1; rx_bit = 1'b0; bit_strobe = 1'b1;
    @(negedge GCLK);
    bit_strobe = 1'b0;
    @(negedge GCLK);
    check_zero("mid_reset");
    RES = 1'b0;
    repeat (IDLE - 1) send_bit(1'b1);
    send_bit(1'b0);                    // restarts the idle count, not a SOF
    repeat (IDLE) send_bit(1'b1);
    run_frame(11'h5A5, 0, 0, 4'd3, 64'hABCD_EF00_0000_0000, 0, 0);

    for (int n = 0; n < 30; n++) begin
      rid   = 11'($urandom);
      rrtr  = ($urandom_range(0, 4) == 0);
      rdlc  = 4'($urandom);
      rdata = {$urandom, $urandom};
      ride  = 1'b0; inj = 0; arg = 0;
      sel   = $urandom_range(0, 9);
      case (sel)
        5: begin inj = 1; arg = $urandom_range(0, 14); end
        6: begin inj = 2; arg = $urandom_range(0, 7); end
        7: ride = 1'b1;
        8: inj = 3;
        9: begin inj = $urandom_range(4, 5); arg = $urandom_range(0, 6); end
        default: ;
      endcase
      run_frame(rid, rrtr, ride, rdlc, rdata, inj, arg);
    end

    repeat (20) @(negedge GCLK);
    check("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
